// File: rtl/pipeline_exec_ctrl_pkg.sv
// rtl/pipeline_exec_ctrl_pkg.sv - shared definitions for the pipeline execution controller
//
// Holds the controller state encodings (also used by the debug unit for
// state readout), the state width and the default halt drain depth.
package pipeline_exec_ctrl_pkg;

   localparam int STATE_W            = 3;
   localparam int DEFAULT_HALT_DRAIN = 4;
   // Drain counter width covers the full HALT_DRAIN range 0..15.
   localparam int DRAIN_W            = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_WAIT_STEP = 3'd2,
      ST_STEP      = 3'd3,
      ST_DONE      = 3'd4
   } state_e;

endpackage

// File: rtl/pipeline_exec_ctrl_rise_edge_det.sv
// rtl/pipeline_exec_ctrl_rise_edge_det.sv - rising edge detector with registered history
//
// Ports:
//   i_clk    clock, rising edge
//   i_reset  asynchronous active-high reset (history cleared to 0)
//   i_sig    input level
//   o_pulse  high for the single cycle in which i_sig is high and was low
//            at the previous clock edge
module rise_edge_det (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sig,
   output logic o_pulse
);

   logic sig_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= i_sig;
      end
   end

   assign o_pulse = i_sig & ~sig_q;

endmodule

// File: rtl/pipeline_exec_ctrl.sv
// rtl/pipeline_exec_ctrl.sv - run/step/halt execution controller for the 5-stage pipeline
//
// Gates the global pipeline enable in continuous or single-step mode, drains
// in-flight instructions after HALT is decoded, and counts enabled cycles.
// Optional watchdog: define PIPE_CTRL_CYCLE_LIMIT_EN to force DONE (with
// o_timeout) once the cycle count reaches MAX_CYCLES.
//
// Ports:
//   i_clk, i_reset    clock (rising edge), asynchronous active-high reset
//   i_start, i_mode   start command and mode (0 continuous, 1 step), IDLE only
//   i_step            step request, one step per rising edge, WAIT_STEP only
//   i_clear           DONE -> IDLE, clears counter, halt state and timeout
//   i_halt_detected   HALT decoded in ID, sampled only in enabled cycles
//   o_pipe_enable     global pipeline enable (RUN or STEP)
//   o_running         RUN, WAIT_STEP or STEP
//   o_done, o_timeout DONE state, DONE reached via watchdog
//   o_cycle_count     saturating count of enabled cycles since last clear
//   o_state           state encoding for debug readout
module pipeline_exec_ctrl
   import pipeline_exec_ctrl_pkg::*;
#(
   parameter int          CNT_WIDTH  = 32,
   parameter int          HALT_DRAIN = DEFAULT_HALT_DRAIN,
   parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic                 i_mode,
   input  logic                 i_step,
   input  logic                 i_clear,
   input  logic                 i_halt_detected,
   output logic                 o_pipe_enable,
   output logic                 o_running,
   output logic                 o_done,
   output logic                 o_timeout,
   output logic [CNT_WIDTH-1:0] o_cycle_count,
   output logic [STATE_W-1:0]   o_state
);

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 halt_pend_q, halt_pend_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic                 step_pulse;
   logic                 enable;
   logic                 halt_done;
   logic                 wdog_hit;

   rise_edge_det u_step_edge (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_sig   (i_step),
      .o_pulse (step_pulse)
   );

`ifdef PIPE_CTRL_CYCLE_LIMIT_EN
   logic timeout_q, timeout_d;
`endif

   assign enable = (state_q == ST_RUN) || (state_q == ST_STEP);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      halt_pend_d = halt_pend_q;
      drain_d     = drain_q;
      halt_done   = 1'b0;
      wdog_hit    = 1'b0;
`ifdef PIPE_CTRL_CYCLE_LIMIT_EN
      timeout_d   = timeout_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               state_d = i_mode ? ST_WAIT_STEP : ST_RUN;
            end
         end
         ST_RUN:       state_d = ST_RUN;
         ST_WAIT_STEP: begin
            // Edges seen in any other state are simply never acted on.
            if (step_pulse) begin
               state_d = ST_STEP;
            end
         end
         ST_STEP:      state_d = ST_WAIT_STEP;
         ST_DONE: begin
            if (i_clear) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               halt_pend_d = 1'b0;
               drain_d     = '0;
`ifdef PIPE_CTRL_CYCLE_LIMIT_EN
               timeout_d   = 1'b0;
`endif
            end
         end
         default:      state_d = ST_IDLE;
      endcase

      if (enable) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end

         if (!halt_pend_q) begin
            if (i_halt_detected) begin
               if (HALT_DRAIN == 0) begin
                  halt_done = 1'b1;
               end else begin
                  halt_pend_d = 1'b1;
                  drain_d     = DRAIN_W'(HALT_DRAIN);
               end
            end
         end else begin
            // drain_q counts the drain cycles still owed including this one,
            // so the cycle that takes it to zero is the last one granted.
            drain_d = drain_q - DRAIN_W'(1);
            if (drain_q <= DRAIN_W'(1)) begin
               halt_done = 1'b1;
            end
         end

`ifdef PIPE_CTRL_CYCLE_LIMIT_EN
         if (cnt_d == CNT_WIDTH'(MAX_CYCLES)) begin
            wdog_hit  = 1'b1;
            timeout_d = 1'b1;
         end
`endif

         if (halt_done || wdog_hit) begin
            state_d = ST_DONE;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         halt_pend_q <= 1'b0;
         drain_q     <= '0;
`ifdef PIPE_CTRL_CYCLE_LIMIT_EN
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         halt_pend_q <= halt_pend_d;
         drain_q     <= drain_d;
`ifdef PIPE_CTRL_CYCLE_LIMIT_EN
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign o_pipe_enable = enable;
   assign o_running     = (state_q == ST_RUN) || (state_q == ST_WAIT_STEP) ||
                          (state_q == ST_STEP);
   assign o_done        = (state_q == ST_DONE);
   assign o_cycle_count = cnt_q;
   assign o_state       = state_q;
`ifdef PIPE_CTRL_CYCLE_LIMIT_EN
   assign o_timeout     = timeout_q;
`else
   assign o_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_exec_ctrl.sv
// tb/tb_pipeline_exec_ctrl.sv - self-checking bench for pipeline_exec_ctrl
module tb_pipeline_exec_ctrl;

   logic clk = 1'b0;
   logic rst, start, mode, step, clear, halt;

   logic       en   [3];
   logic       run  [3];
   logic       done [3];
   logic       to   [3];
   logic [2:0] st   [3];
   logic [31:0] cnt_a, cnt_b;
   logic [3:0]  cnt_c;

   int checks = 0;
   int errors = 0;

   // Instance A: drain 4. Instance B: drain 2, watchdog 8.
   // Instance C: drain 0, 4-bit counter, watchdog value that is never reached.
   int     hd  [3] = '{4, 2, 0};
   longint mx  [3] = '{1000000, 8, 0};
   longint sat [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};

`ifdef PIPE_CTRL_CYCLE_LIMIT_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   pipeline_exec_ctrl #(.CNT_WIDTH(32), .HALT_DRAIN(4), .MAX_CYCLES(32'd1_000_000)) u_dut_a (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_mode(mode), .i_step(step),
      .i_clear(clear), .i_halt_detected(halt),
      .o_pipe_enable(en[0]), .o_running(run[0]), .o_done(done[0]), .o_timeout(to[0]),
      .o_cycle_count(cnt_a), .o_state(st[0]));

   pipeline_exec_ctrl #(.CNT_WIDTH(32), .HALT_DRAIN(2), .MAX_CYCLES(32'd8)) u_dut_b (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_mode(mode), .i_step(step),
      .i_clear(clear), .i_halt_detected(halt),
      .o_pipe_enable(en[1]), .o_running(run[1]), .o_done(done[1]), .o_timeout(to[1]),
      .o_cycle_count(cnt_b), .o_state(st[1]));

   pipeline_exec_ctrl #(.CNT_WIDTH(4), .HALT_DRAIN(0), .MAX_CYCLES(32'd0)) u_dut_c (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_mode(mode), .i_step(step),
      .i_clear(clear), .i_halt_detected(halt),
      .o_pipe_enable(en[2]), .o_running(run[2]), .o_done(done[2]), .o_timeout(to[2]),
      .o_cycle_count(cnt_c), .o_state(st[2]));

   always #5 clk = ~clk;

   // Reference model: phase numbers are the documented state readout values.
   int     m_st   [3];
   longint m_cnt  [3];
   int     m_left [3];   // -1 = no HALT seen, else drain cycles still owed
   bit     m_to   [3];
   bit     m_prev;

   function automatic logic [6:0] dut_stat(input int k);
      return {st[k], en[k], run[k], done[k], to[k]};
   endfunction

   function automatic logic [63:0] dut_cnt(input int k);
      case (k)
         0:       return {32'd0, cnt_a};
         1:       return {32'd0, cnt_b};
         default: return {60'd0, cnt_c};
      endcase
   endfunction

   function automatic logic [6:0] exp_stat(input int k);
      logic e, r, d;
      e = (m_st[k] == 1) || (m_st[k] == 3);
      r = (m_st[k] >= 1) && (m_st[k] <= 3);
      d = (m_st[k] == 4);
      return {3'(m_st[k]), e, r, d, m_to[k]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_st[k] = 0; m_cnt[k] = 0; m_left[k] = -1; m_to[k] = 1'b0;
      end
      m_prev = 1'b0;
   endtask

   task automatic model_tick();
      bit rise;
      rise = step && !m_prev;
      for (int k = 0; k < 3; k++) begin
         int  nxt;
         bit  granted, fin;
         nxt = m_st[k];
         granted = (m_st[k] == 1) || (m_st[k] == 3);
         fin = 1'b0;
         if (m_st[k] == 0 && start) nxt = mode ? 2 : 1;
         if (m_st[k] == 2 && rise)  nxt = 3;
         if (m_st[k] == 3)          nxt = 2;
         if (m_st[k] == 4 && clear) begin
            nxt = 0; m_cnt[k] = 0; m_left[k] = -1; m_to[k] = 1'b0;
         end
         if (granted) begin
            if (m_cnt[k] < sat[k]) m_cnt[k]++;
            if (m_left[k] < 0) begin
               if (halt) begin
                  if (hd[k] == 0) fin = 1'b1;
                  else m_left[k] = hd[k];
               end
            end else begin
               m_left[k]--;
               if (m_left[k] == 0) fin = 1'b1;
            end
            if (WD && m_cnt[k] == mx[k]) begin
               fin = 1'b1; m_to[k] = 1'b1;
            end
            if (fin) nxt = 4;
         end
         m_st[k] = nxt;
      end
      m_prev = step;
   endtask

   // One clock: model follows the edge, outputs compared 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset(); else model_tick();
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("model_stat[%0d]", k), {57'd0, dut_stat(k)}, {57'd0, exp_stat(k)});
         chk($sformatf("model_cnt[%0d]", k), dut_cnt(k), 64'(m_cnt[k]));
      end
   endtask

   task automatic do_step(input logic h);
      step = 1'b1;
      cycle();
      halt = h; step = 1'b0;
      cycle();
      halt = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 0; mode = 0; step = 0; clear = 0; halt = 0;
      model_reset();
      cycle(); cycle();
      chk("reset_stat", {57'd0, dut_stat(0)}, 64'd0);
      chk("reset_cnt", dut_cnt(0), 64'd0);
      rst = 1'b0;
      cycle();

      // Continuous run: 14 enabled cycles, HALT in the 10th, drain of 4.
      start = 1; mode = 0;
      cycle();
      start = 0;
      chk("run_enable_first", {63'd0, en[0]}, 64'd1);
      repeat (4) cycle();
      step = 1; cycle(); step = 0;
      chk("step_in_run_state", {61'd0, st[0]}, 64'd1);
      repeat (4) cycle();
      halt = 1; cycle(); halt = 0;
      repeat (3) cycle();
      chk("drain_last_enable", {63'd0, en[0]}, 64'd1);
      cycle();
      chk("drain_done", {63'd0, done[0]}, 64'd1);
      chk("drain_cnt", dut_cnt(0), 64'd14);
      chk("hd0_cnt", dut_cnt(2), 64'd10);
      clear = 1; cycle(); clear = 0;
      chk("clear_state", {61'd0, st[0]}, 64'd0);
      chk("clear_cnt", dut_cnt(0), 64'd0);

      // Step mode: held step gives one step, second pulse another.
      start = 1; mode = 1;
      cycle();
      start = 0; mode = 0;
      chk("step_wait_state", {61'd0, st[0]}, 64'd2);
      step = 1;
      cycle();
      chk("step_enable", {63'd0, en[0]}, 64'd1);
      cycle();
      chk("step_enable_off", {63'd0, en[0]}, 64'd0);
      repeat (3) cycle();
      step = 0; cycle(); cycle();
      step = 1; cycle();
      step = 0; cycle(); cycle();
      chk("step_cnt2", dut_cnt(0), 64'd2);

      // HALT on step 3, extra HALT on step 4; instance B (drain 2) ends on step 5.
      do_step(1'b1);
      do_step(1'b1);
      chk("step_halt_not_done", {63'd0, done[1]}, 64'd0);
      do_step(1'b0);
      chk("step_halt_done", {63'd0, done[1]}, 64'd1);
      chk("step_halt_cnt", dut_cnt(1), 64'd5);
      clear = 1; cycle(); clear = 0;
      chk("clear_ignored_wait", {61'd0, st[0]}, 64'd2);

      // Continuous run without HALT: watchdog on B, saturation on C, then async reset.
      rst = 1; cycle(); rst = 0;
      start = 1; mode = 0; cycle(); start = 0;
      repeat (8) cycle();
      chk("wdog_cnt", dut_cnt(1), 64'd8);
      chk("wdog_timeout", {63'd0, to[1]}, WD ? 64'd1 : 64'd0);
      chk("wdog_state", {61'd0, st[1]}, WD ? 64'd4 : 64'd1);
      repeat (29) cycle();
      chk("run_cnt37", dut_cnt(0), 64'd37);
      chk("sat_cnt", dut_cnt(2), 64'd15);
      #2;
      rst = 1;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("async_stat[%0d]", k), {57'd0, dut_stat(k)}, 64'd0);
         chk($sformatf("async_cnt[%0d]", k), dut_cnt(k), 64'd0);
      end
      cycle();
      rst = 0;
      cycle(); cycle();
      chk("post_reset_cnt", dut_cnt(0), 64'd0);

      // Drain of 0: HALT in the first enabled cycle ends the run next cycle.
      start = 1; cycle(); start = 0;
      halt = 1; cycle(); halt = 0;
      chk("hd0_done", {63'd0, done[2]}, 64'd1);
      chk("hd0_cnt1", dut_cnt(2), 64'd1);
      start = 1; cycle(); start = 0;
      chk("start_in_done", {61'd0, st[2]}, 64'd4);
      clear = 1; cycle(); clear = 0;
      chk("hd0_clear_state", {61'd0, st[2]}, 64'd0);
      chk("hd0_clear_cnt", dut_cnt(2), 64'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         start = ($urandom_range(0, 9) == 0);
         mode  = $urandom_range(0, 1);
         step  = ($urandom_range(0, 2) == 0);
         clear = ($urandom_range(0, 11) == 0);
         halt  = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 99) == 0);
         cycle();
      end
      rst = 0; start = 0; step = 0; clear = 0; halt = 0;
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
